// File: rtl/mmio_axilite_master_if.sv
// AXI4-Lite bus bundle between the MMIO initiator and the emu-bus slaves.
// Master modport drives AW/W/AR and the B/R readies.
interface mmio_axilite_master_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/mmio_axilite_master.sv
// Single-outstanding AXI4-Lite initiator for CPU MMIO requests,
// with read/write completion counters for emulation debug.
module mmio_axilite_master (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_wen,
    input  logic [31:0]                  req_addr,
    input  logic [31:0]                  req_wdata,
    input  logic [3:0]                   req_wstrb,

    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [31:0]                  resp_rdata,
    output logic                         resp_err,

    mmio_axilite_master_if.master        m_axilite,

    output logic [31:0]                  rd_cnt,
    output logic [31:0]                  wr_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        wen_q;
    logic        aw_pend;
    logic        w_pend;
    logic        aw_done;
    logic        w_done;

    // Every AXI output comes from a register or a state decode only.
    assign m_axilite.arvalid = (state == RD_ADDR);
    assign m_axilite.araddr  = addr_q;
    assign m_axilite.arprot  = 3'b000;
    assign m_axilite.rready  = (state == RD_DATA);

    assign m_axilite.awvalid = aw_pend;
    assign m_axilite.awaddr  = addr_q;
    assign m_axilite.awprot  = 3'b000;
    assign m_axilite.wvalid  = w_pend;
    assign m_axilite.wdata   = wdata_q;
    assign m_axilite.wstrb   = wstrb_q;
    assign m_axilite.bready  = (state == WR_RESP);

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);

    // A channel counts as done if it already fired or fires this cycle.
    assign aw_done = !aw_pend || m_axilite.awready;
    assign w_done  = !w_pend  || m_axilite.wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wen_q      <= 1'b0;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        wen_q   <= req_wen;
                        if (req_wen) begin
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            state   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axilite.arready) begin
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axilite.rvalid) begin
                        resp_rdata <= m_axilite.rdata;
                        resp_err   <= m_axilite.rresp[1];
                        state      <= RESP;
                    end
                end
                WR_REQ: begin
                    if (m_axilite.awready) begin
                        aw_pend <= 1'b0;
                    end
                    if (m_axilite.wready) begin
                        w_pend <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axilite.bvalid) begin
                        resp_rdata <= '0;
                        resp_err   <= m_axilite.bresp[1];
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        if (wen_q) begin
                            wr_cnt <= wr_cnt + 32'd1;
                        end else begin
                            rd_cnt <= rd_cnt + 32'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_axilite_master.sv
// Randomized bench for mmio_axilite_master: behavioural AXI slave,
// transaction-level reference model and per-cycle compare process.
module tb_mmio_axilite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    mmio_axilite_master_if m ();

    mmio_axilite_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .m_axilite  (m),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;

    int cfg_aw = 0;
    int cfg_w  = 0;
    int cfg_b  = 0;
    int cfg_ar = 0;
    int cfg_r  = 0;
    logic [1:0] cfg_bresp = 2'b00;
    logic [1:0] cfg_rresp = 2'b00;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail_stop(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no handshake within bound at %0t", name, $time);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    endtask

    // Peripheral: 16-word register file behind a slave with per-channel waits.
    logic [31:0] smem [16];

    initial begin
        logic s_rst, s_aw, s_w, s_b, s_ar, s_r;
        logic [31:0] s_awa, s_wd, s_ara, aw_a, w_d, r_a;
        logic [3:0] s_ws, w_s;
        logic aw_done, w_done, ar_done, aw_have, w_have;
        logic aw_ld, w_ld, ar_ld, b_pend, r_pend;
        int aw_w, w_w, ar_w, b_w, r_w;
        aw_done = 0; w_done = 0; ar_done = 0; aw_have = 0; w_have = 0;
        aw_ld = 0; w_ld = 0; ar_ld = 0; b_pend = 0; r_pend = 0;
        aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
        aw_a = 0; w_d = 0; w_s = 0; r_a = 0;
        m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = 0;
        m.arready = 0; m.rvalid = 0; m.rdata = 0; m.rresp = 0;
        for (int i = 0; i < 16; i++) smem[i] = 32'hC0DE_0000 + i;
        smem[1] = 32'h1234_5678;
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_aw = m.awvalid && m.awready; s_awa = m.awaddr;
            s_w = m.wvalid && m.wready; s_wd = m.wdata; s_ws = m.wstrb;
            s_b = m.bvalid && m.bready;
            s_ar = m.arvalid && m.arready; s_ara = m.araddr;
            s_r = m.rvalid && m.rready;
            @(posedge clk);
            #1;
            if (s_rst) begin
                aw_done = 0; w_done = 0; ar_done = 0; aw_have = 0; w_have = 0;
                aw_ld = 0; w_ld = 0; ar_ld = 0; b_pend = 0; r_pend = 0;
                m.awready = 0; m.wready = 0; m.bvalid = 0;
                m.arready = 0; m.rvalid = 0;
            end else begin
                if (s_aw) begin aw_done = 1; aw_have = 1; aw_a = s_awa; end
                if (s_w) begin w_done = 1; w_have = 1; w_d = s_wd; w_s = s_ws; end
                if (s_b) begin
                    aw_done = 0; w_done = 0; aw_ld = 0; w_ld = 0;
                    b_pend = 0; m.bvalid = 0;
                end
                if (s_ar) begin ar_done = 1; r_pend = 1; r_w = cfg_r; r_a = s_ara; end
                if (s_r) begin ar_done = 0; ar_ld = 0; r_pend = 0; m.rvalid = 0; end
                if (aw_have && w_have) begin
                    for (int k = 0; k < 4; k++)
                        if (w_s[k]) smem[aw_a[5:2]][8*k +: 8] = w_d[8*k +: 8];
                    aw_have = 0; w_have = 0; b_pend = 1; b_w = cfg_b;
                end
                m.awready = 0;
                if (m.awvalid && !aw_done) begin
                    if (!aw_ld) begin aw_ld = 1; aw_w = cfg_aw; end
                    if (aw_w == 0) m.awready = 1; else aw_w--;
                end
                m.wready = 0;
                if (m.wvalid && !w_done) begin
                    if (!w_ld) begin w_ld = 1; w_w = cfg_w; end
                    if (w_w == 0) m.wready = 1; else w_w--;
                end
                m.arready = 0;
                if (m.arvalid && !ar_done) begin
                    if (!ar_ld) begin ar_ld = 1; ar_w = cfg_ar; end
                    if (ar_w == 0) m.arready = 1; else ar_w--;
                end
                if (b_pend && !m.bvalid) begin
                    if (b_w == 0) begin m.bvalid = 1; m.bresp = cfg_bresp; end
                    else b_w--;
                end
                if (r_pend && !m.rvalid) begin
                    if (r_w == 0) begin
                        m.rvalid = 1; m.rdata = smem[r_a[5:2]]; m.rresp = cfg_rresp;
                    end else r_w--;
                end
            end
        end
    end

    // Reference model: one request in flight, expected response per request.
    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    initial begin
        exp_t q[$];
        exp_t cur;
        exp_t e;
        logic [31:0] shadow [16];
        logic busy, p_ar, p_aw, p_w, p_rv;
        int rd_m, wr_m, n_aw, n_w, n_b, n_ar, n_r;
        busy = 0; p_ar = 0; p_aw = 0; p_w = 0; p_rv = 0;
        rd_m = 0; wr_m = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        for (int i = 0; i < 16; i++) shadow[i] = 32'hC0DE_0000 + i;
        shadow[1] = 32'h1234_5678;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("req_ready", req_ready, !rst && !busy);
                chk("cnts", {rd_cnt, wr_cnt}, {rd_m[31:0], wr_m[31:0]});
                chk("prot", {m.awprot, m.arprot}, 0);
                if (!busy) begin
                    chk("idle_valids", {m.arvalid, m.awvalid, m.wvalid,
                        m.rready, m.bready, resp_valid}, 0);
                end else begin
                    cur = q[0];
                    if (cur.wen) begin
                        chk("wr_no_rd", {m.arvalid, m.rready}, 0);
                        if (m.awvalid) chk("awaddr", m.awaddr, cur.addr);
                        if (m.wvalid)
                            chk("wdata", {m.wstrb, m.wdata}, {cur.wstrb, cur.wdata});
                    end else begin
                        chk("rd_no_wr", {m.awvalid, m.wvalid, m.bready}, 0);
                        if (m.arvalid) chk("araddr", m.araddr, cur.addr);
                    end
                    if (resp_valid)
                        chk("resp", {resp_err, resp_rdata}, {cur.err, cur.rdata});
                end
                if (p_ar) chk("ar_hold", m.arvalid, 1);
                if (p_aw) chk("aw_hold", m.awvalid, 1);
                if (p_w)  chk("w_hold", m.wvalid, 1);
                if (p_rv) chk("resp_hold", resp_valid, 1);
                if (m.awvalid && m.awready) n_aw++;
                if (m.wvalid && m.wready) n_w++;
                if (m.bvalid && m.bready) n_b++;
                if (m.arvalid && m.arready) n_ar++;
                if (m.rvalid && m.rready) n_r++;
                if (resp_valid && resp_ready && busy) begin
                    chk("hs_counts",
                        {8'(n_aw), 8'(n_w), 8'(n_b), 8'(n_ar), 8'(n_r)},
                        cur.wen ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
                    if (cur.wen) wr_m++; else rd_m++;
                    void'(q.pop_front());
                    busy = 0;
                end
                if (req_valid && req_ready) begin
                    e.wen = req_wen; e.addr = req_addr;
                    e.wdata = req_wdata; e.wstrb = req_wstrb;
                    if (req_wen) begin
                        for (int k = 0; k < 4; k++)
                            if (req_wstrb[k])
                                shadow[req_addr[5:2]][8*k +: 8] = req_wdata[8*k +: 8];
                        e.rdata = 0; e.err = cfg_bresp[1];
                    end else begin
                        e.rdata = shadow[req_addr[5:2]]; e.err = cfg_rresp[1];
                    end
                    q.push_back(e);
                    busy = 1;
                    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
                end
                p_ar = m.arvalid && !m.arready;
                p_aw = m.awvalid && !m.awready;
                p_w  = m.wvalid && !m.wready;
                p_rv = resp_valid && !resp_ready;
                if (rst) begin
                    busy = 0; q.delete(); rd_m = 0; wr_m = 0;
                    p_ar = 0; p_aw = 0; p_w = 0; p_rv = 0;
                end
            end
        end
    end

    task automatic send(input logic sync, input logic wen, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int waited);
        if (sync) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1; req_wen = wen; req_addr = a; req_wdata = d; req_wstrb = s;
        for (waited = 0; waited < 50; waited++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (waited == 50) fail_stop("req_accept");
        @(posedge clk);
        #1;
        req_valid = 0; req_wen = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
    endtask

    task automatic wait_resp(input int start, output int lat);
        lat = start;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) return;
        end
        fail_stop("resp_timeout");
    endtask

    task automatic ack_resp(input int hold);
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1;
        resp_ready = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        resp_ready = 0;
    endtask

    task automatic txn(input logic sync, input logic wen, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input int hold);
        int w, lat;
        send(sync, wen, a, d, s, w);
        wait_resp(0, lat);
        ack_resp(hold);
    endtask

    initial begin
        int lat, w;
        rst = 1;
        @(posedge clk);
        #1;
        mon_en = 1;
        @(negedge clk);
        chk("rst_valids", {m.arvalid, m.awvalid, m.wvalid, m.rready,
            m.bready, resp_valid, req_ready}, 0);
        chk("rst_regs", {resp_err, resp_rdata, rd_cnt, wr_cnt}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        send(1, 0, 32'h0000_0004, 0, 0, w);
        @(negedge clk);
        chk("rd_arvalid_c1", m.arvalid, 1);
        wait_resp(1, lat);
        chk("rd_latency", lat, 3);
        chk("rd_data", {resp_err, resp_rdata}, {1'b0, 32'h1234_5678});
        ack_resp(0);
        @(negedge clk);
        chk("rd_cnt_1", rd_cnt, 1);

        send(1, 1, 32'h0000_0004, 32'h0000_0041, 4'b0001, w);
        @(negedge clk);
        chk("wr_valids_c1", {m.awvalid, m.wvalid, m.bready}, 3'b110);
        @(negedge clk);
        chk("wr_valids_c2", {m.awvalid, m.wvalid, m.bready}, 3'b001);
        wait_resp(2, lat);
        chk("wr_latency", lat, 3);
        chk("wr_resp", {resp_err, resp_rdata}, 0);
        ack_resp(0);
        @(negedge clk);
        chk("wr_cnt_1", wr_cnt, 1);

        send(1, 0, 32'h0000_0004, 0, 0, w);
        wait_resp(0, lat);
        chk("rd_after_strb", resp_rdata, 32'h1234_5641);
        ack_resp(0);

        cfg_w = 3;
        send(1, 1, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111, w);
        @(negedge clk);
        chk("dly_c1", {m.awvalid, m.wvalid}, 2'b11);
        @(negedge clk);
        chk("dly_c2", {m.awvalid, m.wvalid, m.wdata}, {2'b01, 32'hDEAD_BEEF});
        wait_resp(2, lat);
        chk("dly_latency", lat, 6);
        ack_resp(0);
        cfg_w = 0;

        cfg_bresp = 2'b10;
        send(1, 1, 32'h0000_000C, 32'h5555_AAAA, 4'b1111, w);
        wait_resp(0, lat);
        chk("bresp_err", {resp_err, resp_rdata}, {1'b1, 32'h0});
        ack_resp(0);
        cfg_bresp = 2'b00;
        cfg_rresp = 2'b11;
        send(1, 0, 32'h0000_0008, 0, 0, w);
        wait_resp(0, lat);
        chk("rresp_err", {resp_err, resp_rdata}, {1'b1, 32'hDEAD_BEEF});
        ack_resp(0);
        cfg_rresp = 2'b00;
        @(negedge clk);
        chk("cnts_3_3", {rd_cnt, wr_cnt}, {32'd3, 32'd3});

        send(1, 0, 32'h0000_0004, 0, 0, w);
        wait_resp(0, lat);
        ack_resp(5);
        send(0, 0, 32'h0000_0008, 0, 0, w);
        chk("accept_after_hs", w, 0);
        wait_resp(0, lat);
        ack_resp(0);

        for (int i = 0; i < 200; i++) begin
            cfg_aw = $urandom_range(0, 3);
            cfg_w  = $urandom_range(0, 3);
            cfg_b  = $urandom_range(0, 3);
            cfg_ar = $urandom_range(0, 3);
            cfg_r  = $urandom_range(0, 3);
            cfg_bresp = 2'($urandom);
            cfg_rresp = 2'($urandom);
            txn(1'($urandom), 1'($urandom), {$urandom} & 32'hFFFF_FFFC,
                $urandom, 4'($urandom), $urandom_range(0, 3));
        end
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_r = 0;
        cfg_bresp = 0; cfg_rresp = 0;

        cfg_ar = 1000;
        send(1, 0, 32'h0000_0010, 0, 0, w);
        @(negedge clk);
        chk("rst_arvalid", m.arvalid, 1);
        @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_valids", {m.arvalid, m.awvalid, m.wvalid, m.rready,
            m.bready, resp_valid}, 0);
        chk("midrst_cnts", {rd_cnt, wr_cnt}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        cfg_ar = 0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        txn(1, 0, 32'h0000_0004, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_cnt", {rd_cnt, wr_cnt}, {32'd1, 32'd0});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
